// File: rtl/teclado_atm_pkg.sv
// teclado_atm_pkg: shared constants and types for the ATM keypad front-end.
//   - key codes for ENTER / BORRAR
//   - debounce FSM state encoding
//   - decimal base used by the amount accumulator
//   - es_digito(): true for key codes 0x0-0x9
package teclado_atm_pkg;

   localparam logic [3:0]  TECLA_ENTER  = 4'hA;
   localparam logic [3:0]  TECLA_BORRAR = 4'hB;
   localparam logic [35:0] BASE_DECIMAL = 36'd10;

   typedef enum logic [1:0] {
      REPOSO,
      ANTIRREBOTE_PRESION,
      PRESIONADA,
      ANTIRREBOTE_LIBERACION
   } estado_t;

   function automatic logic es_digito(input logic [3:0] t);
      return (t <= 4'd9);
   endfunction

endpackage

// File: rtl/teclado_atm_antirrebote.sv
// antirrebote: 2-flop synchronizer plus press/release debounce FSM.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tecla_valida_i      raw key-down level (asynchronous)
//   tecla_i[3:0]        raw key code (asynchronous)
//   tecla_aceptada_o    one-cycle pulse in the cycle a press is accepted
//   tecla_o[3:0]        code of the accepted key (valid with the pulse)
module antirrebote
   import teclado_atm_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tecla_valida_i,
   input  logic [3:0] tecla_i,
   output logic       tecla_aceptada_o,
   output logic [3:0] tecla_o
);

   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CICLOS);

   logic          valida_s1_q, valida_s2_q;
   logic [3:0]    tecla_s1_q, tecla_s2_q;
   estado_t       estado_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    codigo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valida_s1_q <= 1'b0;
         valida_s2_q <= 1'b0;
         tecla_s1_q  <= '0;
         tecla_s2_q  <= '0;
      end else begin
         valida_s1_q <= tecla_valida_i;
         valida_s2_q <= valida_s1_q;
         tecla_s1_q  <= tecla_i;
         tecla_s2_q  <= tecla_s1_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= REPOSO;
         cnt_q    <= '0;
         codigo_q <= '0;
      end else begin
         case (estado_q)
            REPOSO: if (valida_s2_q) begin
               estado_q <= ANTIRREBOTE_PRESION;
               codigo_q <= tecla_s2_q;
               cnt_q    <= CW'(1);
            end
            ANTIRREBOTE_PRESION: begin
               if (!valida_s2_q)                estado_q <= REPOSO;
               else if (tecla_s2_q != codigo_q) begin
                  // code moved under a held key: restart stability window
                  codigo_q <= tecla_s2_q;
                  cnt_q    <= CW'(1);
               end
               else if (cnt_q == CNT_FIN)       estado_q <= PRESIONADA;
               else                             cnt_q    <= cnt_q + CW'(1);
            end
            PRESIONADA: if (!valida_s2_q) begin
               estado_q <= ANTIRREBOTE_LIBERACION;
               cnt_q    <= CW'(1);
            end
            ANTIRREBOTE_LIBERACION: begin
               if (valida_s2_q)           estado_q <= PRESIONADA;
               else if (cnt_q == CNT_FIN) estado_q <= REPOSO;
               else                       cnt_q    <= cnt_q + CW'(1);
            end
            default: estado_q <= REPOSO;
         endcase
      end
   end

   // Decode of the press->held transition; the consumer registers its strobes
   // from this so each strobe lands exactly one cycle after acceptance.
   assign tecla_aceptada_o = (estado_q == ANTIRREBOTE_PRESION) && valida_s2_q &&
                             (tecla_s2_q == codigo_q) && (cnt_q == CNT_FIN);
   assign tecla_o = codigo_q;

endmodule

// File: rtl/teclado_atm.sv
// teclado_atm: keypad front-end for the ATM transaction FSM.
// PIN mode strobes single digits; amount mode accumulates a decimal amount
// into a 32-bit binary value committed on ENTER.
// Optional feature macro: TECLADO_TIMEOUT_EN (amount-mode inactivity timeout).
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   Tecla_Valida, Tecla raw keypad level and code (asynchronous)
//   Modo_Monto          0 = PIN entry, 1 = amount entry
//   Digito, Digito_STB  accepted PIN digit and its one-cycle strobe
//   Monto, Monto_STB    committed amount and its one-cycle strobe
//   Desborde            sticky overflow flag for the amount in progress
//   Tiempo_Agotado      one-cycle timeout pulse (0 without the feature)
module teclado_atm
   import teclado_atm_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int MAX_DIGITOS     = 10,
   parameter int TIMEOUT_CICLOS  = 1000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Tecla_Valida,
   input  logic [3:0]  Tecla,
   input  logic        Modo_Monto,
   output logic [3:0]  Digito,
   output logic        Digito_STB,
   output logic [31:0] Monto,
   output logic        Monto_STB,
   output logic        Desborde,
   output logic        Tiempo_Agotado
);

   localparam int NW = $clog2(MAX_DIGITOS + 1);
   localparam logic [NW-1:0] N_MAX = NW'(MAX_DIGITOS);

   logic          acept;
   logic [3:0]    tecla;
   logic [35:0]   siguiente;
   logic          modo_cambio;

   logic [31:0]   acc_q, acc_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic          desb_q, desb_d;
   logic [3:0]    digito_q, digito_d;
   logic          digito_stb_q, digito_stb_d;
   logic [31:0]   monto_q, monto_d;
   logic          monto_stb_q, monto_stb_d;
   logic          modo_q;

   antirrebote #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_antirrebote (
      .clk              (CLK),
      .rst              (RESET),
      .tecla_valida_i   (Tecla_Valida),
      .tecla_i          (Tecla),
      .tecla_aceptada_o (acept),
      .tecla_o          (tecla)
   );

   assign modo_cambio = (Modo_Monto != modo_q);
   // 36 bits hold 0xFFFF_FFFF*10+9 without wrapping
   assign siguiente   = 36'(acc_q) * BASE_DECIMAL + 36'(tecla);

`ifdef TECLADO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   logic [TW-1:0] inact_q, inact_d;
   logic          tiempo_q, tiempo_d;
`endif

   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      desb_d       = desb_q;
      digito_d     = digito_q;
      digito_stb_d = 1'b0;
      monto_d      = monto_q;
      monto_stb_d  = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      inact_d      = '0;
      tiempo_d     = 1'b0;
`endif
      if (modo_cambio) begin
         // mode switch discards any partial amount and any coincident key
         acc_d  = '0;
         cnt_d  = '0;
         desb_d = 1'b0;
      end else if (acept) begin
         if (!Modo_Monto) begin
            if (es_digito(tecla)) begin
               digito_d     = tecla;
               digito_stb_d = 1'b1;
            end
         end else if (es_digito(tecla)) begin
            if (!desb_q && cnt_q != N_MAX) begin
               if (siguiente[35:32] != 4'd0) desb_d = 1'b1;
               else begin
                  acc_d = siguiente[31:0];
                  cnt_d = cnt_q + NW'(1);
               end
            end
         end else if (tecla == TECLA_ENTER) begin
            if (cnt_q != '0 && !desb_q) begin
               monto_d     = acc_q;
               monto_stb_d = 1'b1;
               acc_d       = '0;
               cnt_d       = '0;
            end
         end else if (tecla == TECLA_BORRAR) begin
            acc_d  = '0;
            cnt_d  = '0;
            desb_d = 1'b0;
         end
      end
`ifdef TECLADO_TIMEOUT_EN
      // counter idles at 0 whenever a key is accepted or no amount is pending
      else if (Modo_Monto && cnt_q != '0) begin
         if (inact_q == TW'(TIMEOUT_CICLOS)) begin
            acc_d    = '0;
            cnt_d    = '0;
            desb_d   = 1'b0;
            tiempo_d = 1'b1;
         end else begin
            inact_d = inact_q + TW'(1);
         end
      end
`endif
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         desb_q       <= 1'b0;
         digito_q     <= '0;
         digito_stb_q <= 1'b0;
         monto_q      <= '0;
         monto_stb_q  <= 1'b0;
         modo_q       <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         desb_q       <= desb_d;
         digito_q     <= digito_d;
         digito_stb_q <= digito_stb_d;
         monto_q      <= monto_d;
         monto_stb_q  <= monto_stb_d;
         modo_q       <= Modo_Monto;
      end
   end

`ifdef TECLADO_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         inact_q  <= '0;
         tiempo_q <= 1'b0;
      end else begin
         inact_q  <= inact_d;
         tiempo_q <= tiempo_d;
      end
   end
   assign Tiempo_Agotado = tiempo_q;
`else
   assign Tiempo_Agotado = 1'b0;
`endif

   assign Digito     = digito_q;
   assign Digito_STB = digito_stb_q;
   assign Monto      = monto_q;
   assign Monto_STB  = monto_stb_q;
   assign Desborde   = desb_q;

endmodule

// File: tb/tb_teclado_atm.sv
module tb_teclado_atm;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        Tecla_Valida = 1'b0;
   logic [3:0]  Tecla = 4'h0;
   logic        Modo_Monto = 1'b0;
   logic [3:0]  Digito;
   logic        Digito_STB;
   logic [31:0] Monto;
   logic        Monto_STB;
   logic        Desborde;
   logic        Tiempo_Agotado;

   int n_cmp = 0, n_err = 0;
   int n_dig = 0, n_mon = 0, n_to = 0, n_both = 0;
   int d0, m0;

   teclado_atm dut (
      .CLK(CLK), .RESET(RESET), .Tecla_Valida(Tecla_Valida), .Tecla(Tecla),
      .Modo_Monto(Modo_Monto), .Digito(Digito), .Digito_STB(Digito_STB),
      .Monto(Monto), .Monto_STB(Monto_STB), .Desborde(Desborde),
      .Tiempo_Agotado(Tiempo_Agotado)
   );

   always #5 CLK = ~CLK;

   // strobe tallies, sampled away from the active edge
   always @(negedge CLK) if (!RESET) begin
      if (Digito_STB) n_dig++;
      if (Monto_STB) n_mon++;
      if (Tiempo_Agotado) n_to++;
      if (Digito_STB && Monto_STB) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge CLK);
      Tecla = k;
      Tecla_Valida = 1'b1;
      repeat (10) @(negedge CLK);
      Tecla_Valida = 1'b0;
      repeat (12) @(negedge CLK);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_digito", {28'd0, Digito}, 0);
      chk("rst_monto", Monto, 0);
      chk("rst_flags", {28'd0, Digito_STB, Monto_STB, Desborde, Tiempo_Agotado}, 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      // PIN entry
      d0 = n_dig; m0 = n_mon;
      press(4'd8); chk("pin_8_cnt", n_dig - d0, 1); chk("pin_8_val", {28'd0, Digito}, 8);
      press(4'd5); chk("pin_5a_cnt", n_dig - d0, 2); chk("pin_5a_val", {28'd0, Digito}, 5);
      press(4'd5); chk("pin_5b_cnt", n_dig - d0, 3); chk("pin_5b_val", {28'd0, Digito}, 5);
      press(4'd1); chk("pin_1_cnt", n_dig - d0, 4); chk("pin_1_val", {28'd0, Digito}, 1);
      press(4'hA); press(4'hB); press(4'hE);
      chk("pin_nondigit_cnt", n_dig - d0, 4);
      chk("pin_no_monto", n_mon - m0, 0);

      // bounce rejection: 1-0-1 at 2-cycle spacing, then held
      d0 = n_dig;
      @(negedge CLK);
      Tecla = 4'd3; Tecla_Valida = 1'b1;
      repeat (2) @(negedge CLK);
      Tecla_Valida = 1'b0;
      repeat (2) @(negedge CLK);
      Tecla_Valida = 1'b1;
      repeat (6) @(negedge CLK);
      chk("bounce_early", {31'd0, Digito_STB}, 0);
      @(negedge CLK);
      chk("bounce_stb", {31'd0, Digito_STB}, 1);
      chk("bounce_val", {28'd0, Digito}, 3);
      @(negedge CLK);
      chk("bounce_one_cycle", {31'd0, Digito_STB}, 0);
      repeat (6) @(negedge CLK);
      Tecla_Valida = 1'b0;
      repeat (12) @(negedge CLK);
      chk("bounce_total", n_dig - d0, 1);

      // amount commit
      Modo_Monto = 1'b1;
      repeat (3) @(negedge CLK);
      d0 = n_dig; m0 = n_mon;
      press(4'd4); press(4'd3); press(4'd6); press(4'd8); press(4'd0);
      press(4'hA);
      chk("amt_monto", Monto, 32'h0000_AAA0);
      chk("amt_stb_cnt", n_mon - m0, 1);
      press(4'hA);
      chk("amt_enter2", n_mon - m0, 1);
      chk("amt_no_digito", n_dig - d0, 0);

      // overflow
      m0 = n_mon;
      press(4'd4); press(4'd2); press(4'd9); press(4'd4); press(4'd9);
      press(4'd6); press(4'd7); press(4'd2); press(4'd9);
      chk("ovf_no_flag_yet", {31'd0, Desborde}, 0);
      press(4'd6);
      chk("ovf_flag", {31'd0, Desborde}, 1);
      chk("ovf_acc", dut.acc_q, 32'd429496729);
      press(4'd5);
      chk("ovf_ignore_acc", dut.acc_q, 32'd429496729);
      press(4'hA);
      chk("ovf_enter_nostb", n_mon - m0, 0);
      chk("ovf_monto_hold", Monto, 32'h0000_AAA0);
      press(4'hB);
      chk("ovf_borrar", {31'd0, Desborde}, 0);
      press(4'd1); press(4'd2); press(4'd8); press(4'hA);
      chk("ovf_after_monto", Monto, 32'h80);
      chk("ovf_after_cnt", n_mon - m0, 1);

      // digit cap: 11th digit ignored, no overflow flag
      press(4'd1);
      for (int i = 0; i < 10; i++) press(4'd0);
      chk("cap_no_flag", {31'd0, Desborde}, 0);
      press(4'hA);
      chk("cap_monto", Monto, 32'd1000000000);

      // reset mid-amount
      press(4'd9); press(4'd9);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("rst2_monto", Monto, 0);
      chk("rst2_digito", {28'd0, Digito}, 0);
      chk("rst2_acc", dut.acc_q, 0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      // mode change discards partial entry
      m0 = n_mon;
      press(4'd7);
      Modo_Monto = 1'b0;
      repeat (3) @(negedge CLK);
      Modo_Monto = 1'b1;
      repeat (3) @(negedge CLK);
      press(4'hA);
      chk("mode_chg_nostb", n_mon - m0, 0);
      chk("mode_chg_monto", Monto, 0);

`ifdef TECLADO_TIMEOUT_EN
      m0 = n_mon;
      press(4'd5);
      repeat (1100) @(negedge CLK);
      chk("to_pulse", n_to, 1);
      press(4'hA);
      chk("to_enter_nostb", n_mon - m0, 0);
`else
      chk("to_off", n_to, 0);
`endif
      chk("stb_exclusive", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
